// File: rtl/countone_mul_arbiter.sv
// Round-robin front end sharing one external pipelined 24x14 multiplier among
// NREQ requesters, with an owner-tag pipeline and a single response port.
module countone_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 3,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*24-1:0]   req_a,
  input  logic [NREQ*14-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [37:0]          rsp_p,
  output logic                 mul_ce,
  output logic [23:0]          mul_din0,
  output logic [13:0]          mul_din1,
  input  logic [37:0]          mul_dout,
  output logic                 busy
);

  // Handshake: a request transfers on the rising edge where req_valid[i] and
  // req_ready[i] are both 1; a response transfers where rsp_valid and
  // rsp_ready are both 1. Valid never waits on ready; ready may follow valid
  // only through candidate selection.

  logic                run_q;
  logic [IDW-1:0]      rr_ptr;
  logic [IDW-1:0]      cand;
  logic                cand_vld;
  logic                issue;
  logic [MUL_LAT-1:0]  tag_vld;
  logic [IDW-1:0]      tag_id [MUL_LAT];

  // A stalled response freezes the multiplier so rsp_p stays on the bus.
  assign mul_ce    = !(rsp_valid && !rsp_ready);
  assign issue     = run_q && mul_ce && cand_vld;
  assign req_ready = issue ? (NREQ'(1) << cand) : '0;

  // First valid requester after the last granted one, wrapping modulo NREQ.
  always_comb begin
    int              idx;
    logic [NREQ-1:0] sel;
    cand     = '0;
    cand_vld = 1'b0;
    idx      = 0;
    sel      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      sel = NREQ'(1) << idx;
      if (!cand_vld && ((req_valid & sel) != '0)) begin
        cand_vld = 1'b1;
        cand     = IDW'(idx);
      end
    end
  end

  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (issue && (cand == IDW'(i))) begin
        mul_din0 = req_a[24*i +: 24];
        mul_din1 = req_b[14*i +: 14];
      end
    end
  end

  // run_q holds off grants until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= 1'b0;
      rr_ptr  <= IDW'(NREQ - 1);
      tag_vld <= '0;
      for (int k = 0; k < MUL_LAT; k++) tag_id[k] <= '0;
    end else begin
      run_q <= 1'b1;
      if (issue) rr_ptr <= cand;
      if (mul_ce) begin
        tag_vld[0] <= issue;
        tag_id[0]  <= issue ? cand : '0;
        for (int k = 1; k < MUL_LAT; k++) begin
          tag_vld[k] <= tag_vld[k-1];
          tag_id[k]  <= tag_id[k-1];
        end
      end
    end
  end

  assign rsp_valid = tag_vld[MUL_LAT-1];
  assign rsp_id    = tag_id[MUL_LAT-1];
  assign rsp_p     = mul_dout;
  assign busy      = |tag_vld;

endmodule
